// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants and state encoding
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   DATA_BITS            = 8;
  localparam logic START_LEVEL          = 1'b0;
  localparam logic STOP_LEVEL           = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter; one-cycle tick on the last cycle of each bit
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic load,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Wrapping on tick makes every bit boundary a restart point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8N1 by default
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        txd,
  output logic        tx_busy,
  output logic [31:0] tx_count
);

  uart_state_t          state;
  uart_state_t          next_state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic [31:0]          count_q;
  logic                 tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign tx_ready = (state == IDLE);
  assign tx_busy  = !tx_ready;
  assign tx_count = count_q;
  assign accept   = tx_valid && tx_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .enable(state != IDLE),
    .load  (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    txd        = STOP_LEVEL;
    case (state)
      IDLE: begin
        if (accept) next_state = START;
      end
      START: begin
        txd = START_LEVEL;
        if (tick) next_state = DATA;
      end
      DATA: begin
        txd = shift_reg[0];
        if (tick && (bit_idx == 3'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd = parity_q;
        if (tick) next_state = STOP;
      end
`endif
      STOP: begin
        txd = STOP_LEVEL;
        if (tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Data is captured only at acceptance, so tx_data may change freely mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        shift_reg <= tx_data;
        bit_idx   <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q  <= ^tx_data;
`endif
      end else if (state == DATA && tick) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end
      if (state == STOP && tick) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule
